// File: rtl/vsim_pkg.sv
// Shared types and defaults for the vsim_send message framer.
package vsim_pkg;

  localparam int VSIM_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BODY   = 2'd2
  } vsim_state_e;

endpackage

// File: rtl/vsim_fifo.sv
// Synchronous FIFO with registered full/empty flags; pointers carry an extra
// wrap bit so full and empty are told apart without a separate counter.
module vsim_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_en   = push && !full_q;
    rd_en   = pop && !empty_q;
    wptr_d  = wr_en ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d  = rd_en ? rptr_q + (AW+1)'(1) : rptr_q;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage is not reset; consumers only look at rdata while non-empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = wptr_q - rptr_q;

endmodule

// File: rtl/vsim_send.sv
// Frames inbound beats into length-prefixed messages for the host; a message
// is only presented once its final beat (or the depth-th beat) is stored.
//
// state  | meaning
// IDLE   | no complete message queued, host_valid low
// HEADER | presenting message length beat
// BODY   | presenting payload beats, remaining count in rem_q
module vsim_send
  import vsim_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = VSIM_DEPTH_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enq__ENA,
  input  logic [width-1:0] enq_v,
  input  logic             enq_last,
  output logic             enq__RDY,
  output logic             host_valid,
  input  logic             host_ready,
  output logic [width-1:0] host_data,
  output logic             host_last,
  output logic             err_overlen
);

  localparam int LW = $clog2(depth) + 1;

  vsim_state_e     state_q;
  logic [LW-1:0]   rem_q;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;

  logic            enq_fire, beat_last;
  logic            data_full, data_empty, data_pop;
  logic            len_full, len_empty, len_push, len_pop, len_more;
  logic [width:0]  data_rdata;
  logic [LW-1:0]   len_rdata, len_wdata, len_count, data_count;
  logic            data_count_unused;

  assign enq__RDY = !data_full && !len_full;

  always_comb begin
    enq_fire  = enq__ENA && enq__RDY;
    // The depth-th beat closes the message even without enq_last.
    beat_last = enq_last || (cnt_q == LW'(depth - 1));
    cnt_d     = cnt_q;
    if (enq_fire) cnt_d = beat_last ? '0 : cnt_q + LW'(1);
    err_d     = err_q || (enq_fire && !enq_last && beat_last);
    len_push  = enq_fire && beat_last;
    len_wdata = cnt_q + LW'(1);
    data_pop  = (state_q == BODY) && host_ready && !data_empty;
    len_pop   = data_pop && data_rdata[width];
    len_more  = (len_count > LW'(1));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!len_empty) state_q <= HEADER;
        end
        HEADER: begin
          if (host_ready) begin
            state_q <= BODY;
            rem_q   <= len_rdata;
          end
        end
        BODY: begin
          if (data_pop) begin
            rem_q <= rem_q - LW'(1);
            // Only lengths already queued behind the current one count, so a
            // length arriving this cycle still takes the IDLE path.
            if (rem_q == LW'(1)) state_q <= len_more ? HEADER : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    host_data = '0;
    case (state_q)
      HEADER:  host_data = width'(len_rdata);
      BODY:    host_data = data_rdata[width-1:0];
      default: host_data = '0;
    endcase
  end

  assign host_valid  = (state_q != IDLE);
  assign host_last   = (state_q == BODY) && (rem_q == LW'(1));
  assign err_overlen = err_q;

  vsim_fifo #(
    .WIDTH(width + 1),
    .DEPTH(depth)
  ) u_data_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (enq_fire),
    .pop  (data_pop),
    .wdata({beat_last, enq_v}),
    .rdata(data_rdata),
    .full (data_full),
    .empty(data_empty),
    .count(data_count)
  );

  vsim_fifo #(
    .WIDTH(LW),
    .DEPTH(depth)
  ) u_len_fifo (
    .clk  (CLK),
    .rst  (RST),
    .push (len_push),
    .pop  (len_pop),
    .wdata(len_wdata),
    .rdata(len_rdata),
    .full (len_full),
    .empty(len_empty),
    .count(len_count)
  );

  assign data_count_unused = ^data_count;

endmodule

// File: doc/vsim_send.md
VSIM_SEND -- requirements
Module: vsim_send

Interface
REQ-001 Parameter: width, 32, beat payload width in bits.
REQ-002 Parameter: depth, 8, data FIFO entries (power of 2, >=2); also maximum message length in beats.
REQ-003 CLK  input  1  sole clock; all logic on posedge CLK.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 port  PipeInLast.server  --  inbound beats: enq__ENA, enq$v[width-1:0], enq$last (inputs); enq__RDY (output).
REQ-006 host_valid  output  1  outbound beat valid.
REQ-007 host_ready  input  1  host accepts beat when high together with host_valid.
REQ-008 host_data  output  width  header or payload beat.
REQ-009 host_last  output  1  final payload beat of the message.
REQ-010 err_overlen  output  1  sticky: a message exceeded depth beats.

Function
REQ-011 enq__RDY SHALL be (data FIFO not full) AND (length FIFO not full), combinational from state registers only; no dependence on enq__ENA.
REQ-012 Beat SHALL be written when enq__ENA && enq__RDY; enq__ENA while !enq__RDY SHALL be ignored.
REQ-013 Input beat counter SHALL count beats of the current message; on a beat with enq$last, or on the depth-th beat, it SHALL push count (1..depth) into a depth-entry length FIFO and clear to 0.
REQ-014 Depth-th beat without enq$last SHALL be treated as last (stored with last=1) and SHALL set err_overlen; following beats start a new message.
REQ-015 Output FSM states IDLE, HEADER, BODY.
REQ-016 IDLE: host_valid=0; when length FIFO non-empty -> HEADER next cycle.
REQ-017 HEADER: host_valid=1, host_data = message length zero-extended to width, host_last=0; on host_ready -> BODY, load remaining count = length.
REQ-018 BODY: host_valid=1, host_data = FIFO head payload, host_last = (remaining==1); on host_ready pop beat, decrement; at last beat pop length FIFO and go HEADER if another length is queued after the pop, else IDLE.
REQ-019 host_data/host_last SHALL hold stable while host_valid && !host_ready.
REQ-020 Simultaneous enqueue and dequeue in one cycle SHALL both occur; occupancy unchanged; full FIFO with simultaneous pop still reports !enq__RDY that cycle (no bypass).
REQ-021 Pointers SHALL wrap modulo depth; full/empty by extra pointer MSB.
REQ-022 Minimum latency: last beat enqueued in cycle N -> header valid in cycle N+2.
REQ-023 A message SHALL never be presented until its last beat is stored; no partial forwarding.

Reset
REQ-024 While RST=1 at a posedge: FIFOs empty, pointers 0, beat counter 0, FSM IDLE, err_overlen 0.
REQ-025 Outputs during/after reset: host_valid=0, host_last=0, host_data=0, enq__RDY=1 from first cycle after reset.
REQ-026 Reset mid-message SHALL discard all buffered and partially received beats; no header emitted for them.

Structure
REQ-027 Package vsim_pkg SHALL hold the FSM state enum (IDLE, HEADER, BODY) and default depth constant.
REQ-028 One sub-module, vsim_fifo (parameterized width/depth, sync, registered flags), SHALL be instantiated twice: data (width+1 bits) and length ($clog2(depth)+1 bits).
REQ-029 Module SHALL be synthesizable (no DPI); simulation-side DPI glue lives elsewhere.

Verification
REQ-030 Single message 3 beats A1,A2,A3(last), host_ready=1 -> host sees 0x3 (last=0), A1, A2, A3(last=1); header at N+2.
REQ-031 9 beats without last, depth=8 -> header 0x8, 8 beats with beat 8 last=1, err_overlen=1; 9th beat appears as new 1-beat message only after it carries last.
REQ-032 host_ready=0 while 8 beats of 1-beat messages arrive -> enq__RDY=0 after 8; raise host_ready -> 8 header/payload pairs in order, none lost.
REQ-033 host_ready toggled every cycle during BODY -> host_data stable while stalled, order preserved.
REQ-034 RST asserted after 2 beats of a 4-beat message -> host_valid stays 0; next 1-beat message emits header 0x1 only.
REQ-035 Back-to-back messages lengths 1 and 2 -> HEADER->BODY->HEADER with no IDLE cycle between.
